// File: rtl/rle_pkg.sv
// Shared FSM encoding and compressed-entry field layout for the RLE decoder.
// Each compressed word is two 16-bit entries; each entry is {byte, count}.
package rle_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ADDR  = 3'd1;
    localparam logic [2:0] S_RD_LATCH = 3'd2;
    localparam logic [2:0] S_EXPAND   = 3'd3;
    localparam logic [2:0] S_WRITE    = 3'd4;
    localparam logic [2:0] S_FLUSH    = 3'd5;

    localparam int ENTRY_W          = 16;
    localparam int BYTE_OFS         = 8;
    localparam int BYTE_W           = 8;
    localparam int CNT_OFS          = 0;
    localparam int CNT_W            = 8;
    localparam int ENTRIES_PER_WORD = 2;

    function automatic logic [ENTRY_W-1:0] entry_of(input logic [31:0] word, input logic sel);
        return sel ? word[ENTRY_W +: ENTRY_W] : word[0 +: ENTRY_W];
    endfunction

endpackage

// File: rtl/rle_byte_packer.sv
// Little-endian 4-byte accumulator: bytes fill lanes 0..3, full after the 4th.
// Pushes while full are dropped; clear has priority over a push.
module rle_byte_packer (
    input  logic        clk,
    input  logic        nreset,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    input  logic        clear_i,
    output logic [31:0] word_o,
    output logic [2:0]  fill_o,
    output logic        full_o
);

    logic [31:0] word_q;
    logic [2:0]  fill_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            word_q <= '0;
            fill_q <= '0;
        end else if (clear_i) begin
            word_q <= '0;
            fill_q <= '0;
        end else if (byte_vld_i && !full_o) begin
            word_q[{fill_q[1:0], 3'b000} +: 8] <= byte_dat_i;
            fill_q <= fill_q + 3'd1;
        end
    end

    assign word_o = word_q;
    assign fill_o = fill_q;
    assign full_o = (fill_q == 3'd4);

endmodule

// File: rtl/rle_decoder.sv
// Reads RLE words from a dpsram port, expands runs one byte per cycle and writes packed words back.
// Memory outputs are combinational from state, so reset forces them to zero immediately.
module rle_decoder
    import rle_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_size,
    input  logic [31:0] message_addr,
    input  logic [31:0] port_A_data_out,
    output logic        port_A_clk,
    output logic [15:0] port_A_addr,
    output logic [31:0] port_A_data_in,
    output logic        port_A_we,
    output logic [31:0] message_size,
    output logic        done
);

    logic [2:0]  state_q, state_d;
    logic [15:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] wr_ptr_q, wr_ptr_d;
    logic [29:0] words_q, words_d;
    logic [31:0] data_q, data_d;
    logic        sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] size_q, size_d;
    logic        done_q, done_d;

    logic        pk_push, pk_clear, pk_full;
    logic [31:0] pk_word;
    logic [2:0]  pk_fill;
    logic [ENTRY_W-1:0] cur_entry, hi_entry;
    logic        unused_bits;

    assign unused_bits = ^{rle_addr[31:16], message_addr[31:16], rle_size[1:0]};
    assign port_A_clk  = clk;
    assign cur_entry   = entry_of(data_q, sel_q);
    assign hi_entry    = entry_of(data_q, 1'b1);

    rle_byte_packer u_packer (
        .clk        (clk),
        .nreset     (nreset),
        .byte_vld_i (pk_push),
        .byte_dat_i (cur_entry[BYTE_OFS +: BYTE_W]),
        .clear_i    (pk_clear),
        .word_o     (pk_word),
        .fill_o     (pk_fill),
        .full_o     (pk_full)
    );

    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        words_d        = words_q;
        data_d         = data_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        size_d         = size_q;
        done_d         = done_q;
        pk_push        = 1'b0;
        pk_clear       = 1'b0;
        port_A_we      = 1'b0;
        port_A_addr    = '0;
        port_A_data_in = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_ptr_d = rle_addr[15:0];
                    wr_ptr_d = message_addr[15:0];
                    words_d  = rle_size[31:2];
                    size_d   = '0;
                    done_d   = 1'b0;
                    sel_d    = 1'b0;
                    cnt_d    = '0;
                    pk_clear = 1'b1;
                    state_d  = (rle_size[31:2] == '0) ? S_FLUSH : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                port_A_addr = rd_ptr_q;
                rd_ptr_d    = rd_ptr_q + 16'd4;
                words_d     = words_q - 30'd1;
                state_d     = S_RD_LATCH;
            end
            S_RD_LATCH: begin
                data_d  = port_A_data_out;
                sel_d   = 1'b0;
                cnt_d   = port_A_data_out[CNT_OFS +: CNT_W];
                state_d = S_EXPAND;
            end
            S_EXPAND: begin
                // An exhausted (or zero-count) entry costs one cycle to advance
                if (cnt_q == '0) begin
                    if (sel_q != 1'(ENTRIES_PER_WORD - 1)) begin
                        sel_d = 1'b1;
                        cnt_d = hi_entry[CNT_OFS +: CNT_W];
                    end else begin
                        state_d = (words_q != '0) ? S_RD_ADDR : S_FLUSH;
                    end
                end else if (!pk_full) begin
                    pk_push = 1'b1;
                    cnt_d   = cnt_q - 8'd1;
                    size_d  = size_q + 32'd1;
                    if (pk_fill == 3'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                port_A_we      = 1'b1;
                port_A_addr    = wr_ptr_q;
                port_A_data_in = pk_word;
                wr_ptr_d       = wr_ptr_q + 16'd4;
                pk_clear       = 1'b1;
                state_d        = S_EXPAND;
            end
            S_FLUSH: begin
                if (pk_fill != 3'd0) begin
                    port_A_we      = 1'b1;
                    port_A_addr    = wr_ptr_q;
                    port_A_data_in = pk_word;
                    wr_ptr_d       = wr_ptr_q + 16'd4;
                end
                pk_clear = 1'b1;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            words_q  <= '0;
            data_q   <= '0;
            sel_q    <= 1'b0;
            cnt_q    <= '0;
            size_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            words_q  <= words_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            done_q   <= done_d;
        end
    end

    assign message_size = size_q;
    assign done         = done_q;

endmodule

// File: doc/rle_decoder.md
RLE_DECODER -- requirements
Module: rle_decoder

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width and meaning, with clock and reset first:
- clk  input  1  system clock.
- nreset  input  1  reset, asynchronous, active-low.
- start  input  1  begin decoding; sampled only in IDLE.
- rle_addr  input  32  byte address of the compressed stream; bits [15:0] used.
- rle_size  input  32  compressed length in bytes; bits [1:0] ignored, words = rle_size>>2.
- message_addr  input  32  byte address for the decoded output; bits [15:0] used.
- port_A_data_out  input  32  dpsram read data, valid one cycle after its address.
- port_A_clk  output  1  equals clk.
- port_A_addr  output  16  dpsram byte address, word-aligned.
- port_A_data_in  output  32  dpsram write data.
- port_A_we  output  1  dpsram write enable.
- message_size  output  32  decoded length in bytes.
- done  output  1  decode complete.

Function
REQ-002 Compressed word format SHALL be two 16-bit entries, processed low entry first. The low entry is byte [15:8] and count [7:0]; the high entry is byte [31:24] and count [23:16].
REQ-003 Count SHALL be an unsigned run length, 1..255; an entry with count 0 SHALL be skipped and SHALL emit no bytes.
REQ-004 Decoded bytes SHALL be packed little-endian: output byte k goes to word message_addr+4*(k>>2), bits 8*(k%4)+7:8*(k%4).
REQ-005 The FSM SHALL have states IDLE, RD_ADDR, RD_LATCH, EXPAND, WRITE and FLUSH.
REQ-006 IDLE: on start=1, the block SHALL load pointers, clear message_size and the byte accumulator, deassert done, and go to RD_ADDR; if rle_size>>2 is 0 it SHALL go to FLUSH instead.
REQ-007 RD_ADDR: the block SHALL drive port_A_addr with the read pointer and we=0, advance the read pointer by 4, and go to RD_LATCH.
REQ-008 RD_LATCH: the block SHALL capture port_A_data_out, select the low entry, and go to EXPAND.
REQ-009 EXPAND: the block SHALL emit one byte per cycle into the accumulator, decrementing the remaining count and incrementing message_size by 1.
REQ-010 In EXPAND, when the accumulator reaches 4 bytes the block SHALL go to WRITE; emission SHALL resume after WRITE.
REQ-011 WRITE: the block SHALL hold port_A_we=1 for exactly one cycle, with port_A_addr set to the write pointer and data_in set to the packed word; it SHALL then advance the write pointer by 4 and clear the accumulator.
REQ-012 On entry exhaustion, the block SHALL switch to the high entry; after the high entry it SHALL go to RD_ADDR if words remain, else to FLUSH.
REQ-013 FLUSH: if 1..3 bytes are pending, the block SHALL write one word with the unused upper bytes zero (one cycle, we=1); it SHALL then set done=1 and return to IDLE.
REQ-014 done SHALL stay 1 until the next accepted start; message_size SHALL stay stable while done=1.
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 Pointer arithmetic SHALL be 16-bit and wrap modulo 2^16 with no error.
REQ-017 port_A_we SHALL be 0 in every state except WRITE and the FLUSH write cycle.
REQ-018 Outside WRITE and the FLUSH write cycle, port_A_data_in SHALL be 0.

Reset
REQ-019 On nreset=0 at any time, including mid-operation, the block SHALL immediately set state=IDLE, done=0, message_size=0, port_A_we=0, port_A_addr=0 and port_A_data_in=0, and clear all pointers, counters and the accumulator.
REQ-020 After reset release, the block SHALL perform no memory access until start.

Structure
REQ-021 Package rle_pkg SHALL hold the FSM state encoding and the entry field offsets and widths (byte and count positions, entry width 16, ENTRIES_PER_WORD=2).
REQ-022 Sub-module rle_byte_packer SHALL hold the 4-byte accumulator: byte-valid in, byte-lane fill counter, full flag, packed word out and clear.

Verification
REQ-023 A bench SHALL cover rle_size=4, word 0x42024103 -> writes 0x42414141 then 0x00000042; message_size=5; done=1.
REQ-024 A bench SHALL cover word 0x00004104 -> a single write 0x41414141; the count-0 high entry is skipped; message_size=4.
REQ-025 A bench SHALL cover word 0x00007FFF -> 64 writes, the last 0x007F7F7F; message_size=255; exactly 64 we pulses.
REQ-026 A bench SHALL cover rle_size=0 with start -> no we pulses; done=1 within 3 cycles; message_size=0.
REQ-027 A bench SHALL cover nreset pulsed low during EXPAND -> same cycle we=0, done=0, message_size=0; a following start decodes 0x42024103 correctly.
REQ-028 A bench SHALL cover start reasserted mid-decode -> ignored; output is identical to REQ-023.
